// File: rtl/split_pkg.sv
// Shared types and defaults for the split router: select encoding and payload width.
package split_pkg;

  localparam int unsigned WIDTH_DEFAULT = 33;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

  typedef logic [WIDTH_DEFAULT-1:0] payload_t;

endpackage

// File: rtl/split_fifo.sv
// Small synchronous FIFO with a registered head; full is derived from registered occupancy only.
module split_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_en, pop_en;

  assign full       = (occ_q == OCC_W'(DEPTH));
  assign head_valid = (occ_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

  always_comb begin
    push_en  = push && !full;
    pop_en   = pop && head_valid;
    wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    if (push_en && !pop_en) begin
      occ_d = occ_q + 1'b1;
    end else if (pop_en && !push_en) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/split_router.sv
// Joins one data token with one select token and routes the payload to per-port FIFOs A or B.
module split_router
  import split_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             i_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  sel_t             target;
  logic             fire, push_a, push_b, full_a, full_b, pop_a, pop_b;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  // Space uses registered occupancy only, so ready never depends on a_ready/b_ready.
  always_comb begin
    target = sel_t'(s_data);
    fire   = s_valid && i_valid && !reset &&
             ((target == SEL_A) ? !full_a : !full_b);
    push_a = fire && (target == SEL_A);
    push_b = fire && (target == SEL_B);
  end

  assign s_ready = fire;
  assign i_ready = fire;

  split_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (i_data),
    .full      (full_a),
    .pop       (a_ready),
    .head_valid(a_valid),
    .head_data (a_data)
  );

  split_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (i_data),
    .full      (full_b),
    .pop       (b_ready),
    .head_valid(b_valid),
    .head_data (b_data)
  );

  always_comb begin
    pop_a   = a_valid && a_ready;
    pop_b   = b_valid && b_ready;
    cnt_a_d = pop_a ? cnt_a_q + 1'b1 : cnt_a_q;
    cnt_b_d = pop_b ? cnt_b_q + 1'b1 : cnt_b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign count_a = cnt_a_q;
  assign count_b = cnt_b_q;

endmodule

// File: tb/tb_split_router.sv
// Directed table-driven bench for split_router: joins, routing, back-pressure, reset flush.
module tb_split_router;

  localparam int unsigned W = 33;
  localparam int unsigned C = 16;

  logic         clk = 1'b0;
  logic         reset, s_valid, s_data, s_ready, i_valid, i_ready;
  logic [W-1:0] i_data, a_data, b_data;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [C-1:0] count_a, count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  split_router #(.WIDTH(W), .DEPTH(2), .CNT_W(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_ready(i_ready),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_ready(b_ready),
    .count_a(count_a),
    .count_b(count_b)
  );

  typedef struct {
    logic         rst, sv, sd, iv;
    logic [W-1:0] id;
    logic         ar, br;
    logic         rdy, av;
    logic [W-1:0] ad;
    logic         bv;
    logic [W-1:0] bd;
    int           ca, cb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic sv, logic sd, logic iv, logic [W-1:0] id,
                              logic ar, logic br, logic rdy, logic av, logic [W-1:0] ad,
                              logic bv, logic [W-1:0] bd, int ca, int cb);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sd = sd; v.iv = iv; v.id = id; v.ar = ar; v.br = br;
    v.rdy = rdy; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ca = ca; v.cb = cb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; s_valid = v.sv; s_data = v.sd; i_valid = v.iv; i_data = v.id;
    a_ready = v.ar; b_ready = v.br;
  endtask

  initial begin
    // Reset with both tokens offered: nothing may be consumed.
    reset = 1'b1; s_valid = 1'b1; s_data = 1'b0; i_valid = 1'b1; i_data = 33'h5;
    a_ready = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_i_ready", 64'(i_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_a_valid", 64'(a_valid), 64'(0));
    chk("rst_b_valid", 64'(b_valid), 64'(0));
    chk("rst_a_data", 64'(a_data), 64'(0));
    chk("rst_b_data", 64'(b_data), 64'(0));
    chk("rst_count_a", 64'(count_a), 64'(0));
    chk("rst_count_b", 64'(count_b), 64'(0));
    @(posedge clk); #1;

    //            rst sv sd iv id       ar br | rdy av ad      bv bd      ca cb
    // single packet to A
    vecs.push_back(mk(0, 1, 0, 1, 33'hAA, 1, 1,   1, 0, 0,      0, 0,      0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 1, 33'hAA, 0, 0,      0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      0, 0,      1, 0));
    // alternating A/B
    vecs.push_back(mk(0, 1, 0, 1, 33'h1,  1, 1,   1, 0, 0,      0, 0,      1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 33'h2,  1, 1,   1, 1, 33'h1,  0, 0,      1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 33'h3,  1, 1,   1, 0, 0,      1, 33'h2,  2, 0));
    vecs.push_back(mk(0, 1, 1, 1, 33'h4,  1, 1,   1, 1, 33'h3,  0, 0,      2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      1, 33'h4,  3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      0, 0,      3, 2));
    // A stalled: fill, hold third, B still routes
    vecs.push_back(mk(0, 1, 0, 1, 33'h10, 0, 1,   1, 0, 0,      0, 0,      3, 2));
    vecs.push_back(mk(0, 1, 0, 1, 33'h11, 0, 1,   1, 1, 33'h10, 0, 0,      3, 2));
    vecs.push_back(mk(0, 1, 0, 1, 33'h12, 0, 1,   0, 1, 33'h10, 0, 0,      3, 2));
    vecs.push_back(mk(0, 1, 0, 1, 33'h12, 0, 1,   0, 1, 33'h10, 0, 0,      3, 2));
    vecs.push_back(mk(0, 1, 1, 1, 33'h20, 0, 1,   1, 1, 33'h10, 0, 0,      3, 2));
    // full with a_ready in the same cycle: no pass-through
    vecs.push_back(mk(0, 1, 0, 1, 33'h12, 1, 1,   0, 1, 33'h10, 1, 33'h20, 3, 2));
    vecs.push_back(mk(0, 1, 0, 1, 33'h12, 1, 1,   1, 1, 33'h11, 0, 0,      4, 3));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 1, 33'h12, 0, 0,      5, 3));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      0, 0,      6, 3));
    // data without select waits
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 1, 1, 33'h7, 1, 1,   0, 0, 0,      0, 0,      6, 3));
    vecs.push_back(mk(0, 1, 1, 1, 33'h7,  1, 1,   1, 0, 0,      0, 0,      6, 3));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 0,   0, 0, 0,      1, 33'h7,  6, 3));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      1, 33'h7,  6, 3));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      0, 0,      6, 4));
    // buffer 2 in A, 1 in B, then reset flushes everything
    vecs.push_back(mk(0, 1, 0, 1, 33'h31, 0, 0,   1, 0, 0,      0, 0,      6, 4));
    vecs.push_back(mk(0, 1, 0, 1, 33'h32, 0, 0,   1, 1, 33'h31, 0, 0,      6, 4));
    vecs.push_back(mk(0, 1, 1, 1, 33'h41, 0, 0,   1, 1, 33'h31, 0, 0,      6, 4));
    vecs.push_back(mk(1, 1, 1, 1, 33'h50, 0, 0,   0, 1, 33'h31, 1, 33'h41, 6, 4));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      0, 0,      0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      0, 0,      0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 33'h0,  1, 1,   0, 0, 0,      0, 0,      0, 0));

    foreach (vecs[n]) begin
      drive(vecs[n]);
      @(negedge clk);
      chk($sformatf("v%0d_s_ready", n), 64'(s_ready), 64'(vecs[n].rdy));
      chk($sformatf("v%0d_i_ready", n), 64'(i_ready), 64'(vecs[n].rdy));
      chk($sformatf("v%0d_a_valid", n), 64'(a_valid), 64'(vecs[n].av));
      chk($sformatf("v%0d_b_valid", n), 64'(b_valid), 64'(vecs[n].bv));
      if (vecs[n].av) chk($sformatf("v%0d_a_data", n), 64'(a_data), 64'(vecs[n].ad));
      if (vecs[n].bv) chk($sformatf("v%0d_b_data", n), 64'(b_data), 64'(vecs[n].bd));
      chk($sformatf("v%0d_count_a", n), 64'(count_a), 64'(vecs[n].ca));
      chk($sformatf("v%0d_count_b", n), 64'(count_b), 64'(vecs[n].cb));
      @(posedge clk); #1;
    end

    // After the flush the heads read zero again.
    @(negedge clk);
    chk("post_rst_a_data", 64'(a_data), 64'(0));
    chk("post_rst_b_data", 64'(b_data), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/split_router.md
Name: split_router

Overview:
- Clocked two-way demultiplexer; the inverse of the codebase's select-driven merge.
- Joins one data token on I with one select token on S, then routes the data to output A (sel=0) or B (sel=1).
- Each output has its own small FIFO so a stalled consumer on one side does not block traffic to the other side until that side's FIFO is full.
- Sits between the packet source and the two downstream consumer pipelines. Its 33-bit payload matches the merge data path.

Parameters:
- WIDTH, 33, payload width of I, A and B.
- DEPTH, 2, entries per output FIFO; must be a power of 2 and at least 2.
- CNT_W, 16, width of the per-port delivered-packet counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  select token present.
- s_data  in  1  select value: 0 routes to A, 1 routes to B.
- s_ready  out  1  select token consumed this cycle.
- i_valid  in  1  input data token present.
- i_data  in  WIDTH  input payload.
- i_ready  out  1  data token consumed this cycle.
- a_valid  out  1  A FIFO head valid.
- a_data  out  WIDTH  A FIFO head payload.
- a_ready  in  1  A consumer accepts.
- b_valid  out  1  B FIFO head valid.
- b_data  out  WIDTH  B FIFO head payload.
- b_ready  in  1  B consumer accepts.
- count_a  out  CNT_W  packets delivered on A (counts a_valid&&a_ready).
- count_b  out  CNT_W  packets delivered on B.

Behaviour:
- Reset (synchronous): while reset=1 at an edge, both FIFOs empty, pointers and occupancy 0, count_a=count_b=0.
  - a_valid=b_valid=0 and a_data=b_data=0 from the cycle after that edge.
  - s_ready=i_ready=0 whenever reset=1. They are gated combinationally, so no token is consumed during reset.
- Reset mid-operation discards all buffered packets. Half-arrived joins leave no residue, because consumption is atomic.
- Join/fire:
  - fire = s_valid && i_valid && space(target) && !reset, where target = s_data.
  - space(X) = occupancy(X) < DEPTH.
  - There is no pass-through when full: a pop in the same cycle does not create space. This keeps ready free of a combinational path from a_ready/b_ready.
  - s_ready = i_ready = fire. Both tokens are always consumed together, never one alone.
- Handshake rules:
  - s_ready/i_ready depend on s_valid, i_valid, s_data and registered occupancy only.
  - a_valid/b_valid are purely registered: occupancy != 0.
  - a_data/b_data come from the FIFO head register/array, not from i_data.
  - Once asserted, a_valid stays high with a_data stable until a_ready is seen (AXI-style). The same applies to b_valid/b_data.
- Latency: a token accepted at edge t is visible at the output (x_valid=1) in the cycle after edge t. That is 1 cycle when the FIFO was empty.
  - Throughput: 1 packet/cycle per port sustained while the consumer keeps x_ready=1.
- Ordering: strict FIFO per port. No ordering relation between A and B.
- FIFO per port:
  - Push on fire&&target==X; pop on x_valid&&x_ready.
  - Simultaneous push and pop (non-full, non-empty) leaves occupancy unchanged.
  - Push while empty with no pop sets occupancy to 1.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Blocking: when the target FIFO is full, the pending S/I pair is held off. Upstream must keep s_valid/s_data/i_valid/i_data stable. The other port keeps draining.
- Counters: increment on each pop of their own port and wrap from 2^CNT_W-1 to 0. Simultaneous A and B pops increment both.
- There is no error state. s_valid without i_valid (or the reverse) simply waits.

Decomposition:
- split_pkg: WIDTH_DEFAULT=33, sel_t enum {SEL_A=1'b0, SEL_B=1'b1}, payload_t typedef logic [32:0].
- One sub-module, split_fifo (parameters WIDTH, DEPTH):
  - push/push_data/full, pop/head_valid/head_data, synchronous active-high reset.
  - Instantiated twice.
- Join logic and counters stay in split_router.

Test Plan:
- Reset then sel=0, data=33'h0_0000_00AA, a_ready=1 -> i_ready=s_ready=1 for 1 cycle; next cycle a_valid=1, a_data=AA; count_a=1 after the handshake; b_valid stays 0.
- Alternate sel 0,1,0,1 with data 1,2,3,4, both readies=1 -> A sees 1,3 and B sees 2,4 in order; count_a=count_b=2; one accept per cycle.
- a_ready=0, push sel=0 three times with data 10,11,12 -> first two accepted; third held with i_ready=0 and stable inputs; then sel=1/data 20 (after reordering the source) still routes to B; raising a_ready drains 10,11 then accepts 12.
- A FIFO full, a_ready=1 in the same cycle as a new sel=0 offer -> offer not accepted that cycle (i_ready=0) and accepted the next cycle; order 10,11,12 preserved.
- Only i_valid=1 for 5 cycles with s_valid=0 -> no consumption, i_ready=0; then s_valid=1 -> single joint accept.
- Reset asserted with 2 packets buffered in A and 1 in B -> next cycle a_valid=b_valid=0 and counts=0; those packets never appear after reset is released.
